// File: rtl/instr_pkg.sv
// Shared instruction IDs, MIPS opcode/funct constants and loader state encoding.
package instr_pkg;

   typedef enum logic [4:0] {
      ADD  = 5'd0,  SUB  = 5'd1,  AND  = 5'd2,  OR   = 5'd3,
      XOR  = 5'd4,  NOR  = 5'd5,  SLT  = 5'd6,  JR   = 5'd7,
      SLL  = 5'd8,  SRL  = 5'd9,  SRA  = 5'd10, SW   = 5'd11,
      LW   = 5'd12, ADDI = 5'd13, ANDI = 5'd14, ORI  = 5'd15,
      XORI = 5'd16, SLTI = 5'd17, BEQ  = 5'd18, BNE  = 5'd19,
      JMP  = 5'd20, JAL  = 5'd21
   } instr_id_t;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;

   localparam logic [5:0] OPC_SW   = 6'h2B;
   localparam logic [5:0] OPC_LW   = 6'h23;
   localparam logic [5:0] OPC_ADDI = 6'h08;
   localparam logic [5:0] OPC_ANDI = 6'h0C;
   localparam logic [5:0] OPC_ORI  = 6'h0D;
   localparam logic [5:0] OPC_XORI = 6'h0E;
   localparam logic [5:0] OPC_SLTI = 6'h0A;
   localparam logic [5:0] OPC_BEQ  = 6'h04;
   localparam logic [5:0] OPC_BNE  = 6'h05;
   localparam logic [5:0] OPC_JMP  = 6'h02;
   localparam logic [5:0] OPC_JAL  = 6'h03;

   // Word layout classes; each decides which fields are forced to zero.
   typedef enum logic [2:0] {
      FMT_ALU, FMT_SHIFT, FMT_JR, FMT_I, FMT_J
   } instr_fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE, ST_LOAD, ST_FULL
   } load_state_t;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: symbolic instruction (ID + fields) to a 32-bit MIPS word.
module instr_field_encoder
   import instr_pkg::*;
(
   input  logic [4:0]  i_op,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word,
   output logic        o_legal
);

   logic [5:0]  w_funct;
   logic [5:0]  w_opcode;
   instr_fmt_t  w_fmt;

   always_comb begin
      w_funct  = 6'd0;
      w_opcode = 6'd0;
      w_fmt    = FMT_ALU;
      o_legal  = 1'b1;
      case (i_op)
         ADD:  w_funct = FN_ADD;
         SUB:  w_funct = FN_SUB;
         AND:  w_funct = FN_AND;
         OR:   w_funct = FN_OR;
         XOR:  w_funct = FN_XOR;
         NOR:  w_funct = FN_NOR;
         SLT:  w_funct = FN_SLT;
         JR:   begin w_funct = FN_JR;  w_fmt = FMT_JR;    end
         SLL:  begin w_funct = FN_SLL; w_fmt = FMT_SHIFT; end
         SRL:  begin w_funct = FN_SRL; w_fmt = FMT_SHIFT; end
         SRA:  begin w_funct = FN_SRA; w_fmt = FMT_SHIFT; end
         SW:   begin w_opcode = OPC_SW;   w_fmt = FMT_I; end
         LW:   begin w_opcode = OPC_LW;   w_fmt = FMT_I; end
         ADDI: begin w_opcode = OPC_ADDI; w_fmt = FMT_I; end
         ANDI: begin w_opcode = OPC_ANDI; w_fmt = FMT_I; end
         ORI:  begin w_opcode = OPC_ORI;  w_fmt = FMT_I; end
         XORI: begin w_opcode = OPC_XORI; w_fmt = FMT_I; end
         SLTI: begin w_opcode = OPC_SLTI; w_fmt = FMT_I; end
         BEQ:  begin w_opcode = OPC_BEQ;  w_fmt = FMT_I; end
         BNE:  begin w_opcode = OPC_BNE;  w_fmt = FMT_I; end
         JMP:  begin w_opcode = OPC_JMP;  w_fmt = FMT_J; end
         JAL:  begin w_opcode = OPC_JAL;  w_fmt = FMT_J; end
         default: o_legal = 1'b0;
      endcase
   end

   always_comb begin
      o_word = 32'd0;
      if (o_legal) begin
         case (w_fmt)
            FMT_ALU:   o_word = {6'd0, i_rs, i_rt, i_rd, 5'd0, w_funct};
            FMT_SHIFT: o_word = {6'd0, 5'd0, i_rt, i_rd, i_shamt, w_funct};
            FMT_JR:    o_word = {6'd0, i_rs, 15'd0, w_funct};
            FMT_I:     o_word = {w_opcode, i_rs, i_rt, i_imm};
            FMT_J:     o_word = {w_opcode, i_target};
            default:   o_word = 32'd0;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic instructions in, encodes them and writes consecutive imem words.
module instr_encoder_loader
   import instr_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              err,
   output logic              busy
);

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   load_state_t       r_state;
   load_state_t       w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_wdata;
   logic [31:0]       w_word;
   logic              w_legal;
   logic              w_accept;
   logic              w_write;

   instr_field_encoder u_enc (
      .i_op     (in_op),
      .i_rs     (in_rs),
      .i_rt     (in_rt),
      .i_rd     (in_rd),
      .i_shamt  (in_shamt),
      .i_imm    (in_imm),
      .i_target (in_target),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   // Ready never looks at in_valid so upstream can wait on it safely.
   assign in_ready = (r_state == ST_LOAD) & ~start & (r_count < DEPTH_C);
   assign w_accept = in_valid & in_ready;
   assign w_write  = w_accept & w_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_next = ST_LOAD;
         ST_LOAD: begin
            if (start)                   w_state_next = ST_LOAD;
            else if (finish)             w_state_next = ST_IDLE;
            else if (r_count == DEPTH_C) w_state_next = ST_FULL;
         end
         ST_FULL: begin
            if (start)       w_state_next = ST_LOAD;
            else if (finish) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= 32'd0;
      end else begin
         r_we <= w_write;
         if (start) begin
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
         end else begin
            if (w_write) begin
               r_addr  <= r_addr + 1'b1;
               r_count <= r_count + 1'b1;
            end
            if (w_accept & ~w_legal) r_err <= 1'b1;
         end
         if (w_write) begin
            r_waddr <= r_addr;
            r_wdata <= w_word;
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_waddr;
   assign imem_wdata = r_wdata;
   assign count      = r_count;
   assign err        = r_err;
   assign busy       = (r_state == ST_LOAD);

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the pipeline's instruction-traits decoder: accepts symbolic instructions (instruction ID plus fields) over a valid/ready stream.
- Encodes each into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses.
- Used by the bench/boot path to load test programs into imem before the pipeline is released from stall.

Parameters:
- DEPTH, 64, number of imem words the loader may write (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), width of the imem word address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse; begin a load session at word address 0
- finish  in  1  pulse; end the load session
- in_valid  in  1  instruction offered
- in_ready  out  1  loader can accept this cycle
- in_op  in  5  instruction ID (see package)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written this session
- err  out  1  sticky flag: an illegal in_op was seen
- busy  out  1  state is LOAD

Behaviour:
- Reset and reset-mid-session: state IDLE; addr=0; count=0; err=0; imem_we=0; imem_addr=0; imem_wdata=0.
- States and transitions:
  - IDLE: start → LOAD.
  - LOAD: finish → IDLE; count==DEPTH → FULL; start → LOAD with addr and count cleared.
  - FULL: start → LOAD with addr and count cleared; finish → IDLE.
- start clears err and count; it has priority over finish and over a handshake in the same cycle.
- in_ready = (state==LOAD) & ~start & (count<DEPTH). It is combinational only from state, count and start, never from in_valid.
- Handshake: in_valid&in_ready. There is one cycle of latency: the next cycle drives imem_we=1, imem_addr=addr, imem_wdata=encoding; addr and count then increment.
- imem_we is high for exactly one cycle per legal accepted op.
- Back-to-back: one write per cycle at full throughput.
- Illegal op (in_op>21): the handshake completes but nothing is written; addr and count do not advance; err←1.
- finish with a handshake in the same cycle: that word is still written the next cycle, then the state is IDLE.
- When count reaches DEPTH, in_ready drops the same cycle the last write is registered. addr wraps to 0 but is unused until the next start.
- Encoding rules:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
  - SLL/SRL/SRA: rs field forced to 0.
  - JR: rt, rd and shamt forced to 0.
  - ADD..SLT: shamt forced to 0.
  - I-type: {opcode, rs, rt, imm}.
  - J-type: {opcode, target}.
- Opcode/funct values:
  - ADD 20h, SUB 22h, AND 24h, OR 25h, XOR 26h, NOR 27h, SLT 2Ah, JR 08h, SLL 00h, SRL 02h, SRA 03h (funct).
  - SW 2Bh, LW 23h, ADDI 08h, ANDI 0Ch, ORI 0Dh, XORI 0Eh, SLTI 0Ah, BEQ 04h, BNE 05h, JMP 02h, JAL 03h (opcode).

Decomposition:
- Shared package instr_pkg holds:
  - the instr_id_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, JR=7, SLL=8, SRL=9, SRA=10, SW=11, LW=12, ADDI=13, ANDI=14, ORI=15, XORI=16, SLTI=17, BEQ=18, BNE=19, JMP=20, JAL=21;
  - the opcode and funct constants above;
  - the loader state enum.
- One sub-module: instr_field_encoder. It is purely combinational: (op, fields) → (word, legal).
- The loader wraps the encoder with the FSM, address counter and output register.

Test Plan:
- Reset asserted mid-session (count=5, err=1) → next cycle all outputs 0, busy=0, in_ready=0.
- start, then ADD rs=1 rt=2 rd=3 → 1 cycle later imem_we=1, addr=0, wdata=32'h00221820; count=1.
- Back-to-back ADDI rs=0 rt=8 imm=16'hFFFF, JAL target=26'h0000010, SRA rt=9 rd=10 shamt=4 rs=7:
  - writes 2008FFFF @0, 0C000010 @1, 00095103 @2 on consecutive cycles;
  - SRA's rs is ignored.
- in_op=25 between two legal ops → no write for it; err=1; legal ops land at addrs 0 and 1.
- DEPTH=4: offer 6 ops with in_valid held high → 4 writes; in_ready low after the 4th accept; state FULL; start → count=0, err=0, next write at addr 0.
- Same-cycle conflicts:
  - start with in_valid → no accept, no write;
  - finish with handshake → that word is written, then busy=0.
